// File: rtl/golden_nonce_scanner_if.sv
// Bundle of the scanner's control, pipeline and golden-nonce handshake signals.
//   master: host/bench side. It drives the scan controls, the pipeline hash and golden_ready.
//   slave : scanner side. It drives nonce issue, the golden FIFO head, busy and overflow.
// Signals:
//   start, abort, nonce_start, nonce_end, target   scan control (host -> scanner)
//   nonce_out, issue_valid                          nonce issue to the hash pipeline
//   hash_in                                         final hash from the pipeline
//   golden_valid, golden_ready, golden_nonce        golden-nonce FIFO handshake
//   busy, overflow                                  status
interface golden_nonce_scanner_if;
  logic         start;
  logic         abort;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic [255:0] target;
  logic [31:0]  nonce_out;
  logic         issue_valid;
  logic [255:0] hash_in;
  logic         golden_valid;
  logic         golden_ready;
  logic [31:0]  golden_nonce;
  logic         busy;
  logic         overflow;

  modport master (
    output start, abort, nonce_start, nonce_end, target, hash_in, golden_ready,
    input  nonce_out, issue_valid, golden_valid, golden_nonce, busy, overflow
  );

  modport slave (
    input  start, abort, nonce_start, nonce_end, target, hash_in, golden_ready,
    output nonce_out, issue_valid, golden_valid, golden_nonce, busy, overflow
  );
endinterface

// File: rtl/golden_nonce_scanner.sv
// Golden-nonce scanner for a fixed-latency double-SHA256 pipeline.
// The scanner issues one nonce per cycle over an inclusive, wrapping range.
// It tracks in-flight issues with a LATENCY-bit valid shift register.
// Each returned hash is compared against the latched target.
// Winning nonces are queued in a small FIFO.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      golden_nonce_scanner_if.slave (controls, issue, hash, FIFO, status)
module golden_nonce_scanner #(
  parameter int unsigned LATENCY    = 128,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  golden_nonce_scanner_if.slave bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e             state_q;
  logic [31:0]        nonce_q;
  logic [31:0]        end_q;
  logic [255:0]       target_q;
  logic               issue_q;
  logic [LATENCY-1:0] vld_sr_q;
  logic [31:0]        check_nonce_q;
  logic               cmp_valid_q;
  logic               cmp_golden_q;
  logic [31:0]        cmp_nonce_q;
  logic               overflow_q;
  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_q;
  logic [AW:0]        rd_ptr_q;

  logic               start_ok;
  logic [255:0]       hash_v;
  logic               tail;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic               push_ok;
  logic               drop;

  assign start_ok = bus.start && !bus.abort && (state_q == StIdle);
  assign tail     = vld_sr_q[LATENCY-1];

  // Byte-reverse each word. The word order already matches the big-endian value:
  // H7 occupies the top word in both layouts.
  always_comb begin
    hash_v = '0;
    for (int w = 0; w < 8; w++) begin
      hash_v[w*32 +: 32] = {bus.hash_in[w*32 +: 8], bus.hash_in[w*32+8 +: 8],
                            bus.hash_in[w*32+16 +: 8], bus.hash_in[w*32+24 +: 8]};
    end
  end

  // Scan control
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      nonce_q  <= '0;
      end_q    <= '0;
      target_q <= '0;
      issue_q  <= 1'b0;
    end else if (bus.abort) begin
      state_q <= StIdle;
      issue_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q  <= StRun;
            nonce_q  <= bus.nonce_start;
            end_q    <= bus.nonce_end;
            target_q <= bus.target;
            issue_q  <= 1'b1;
          end
        end
        StRun: begin
          nonce_q <= nonce_q + 32'd1;
          if (nonce_q == end_q) begin
            state_q <= StDrain;
            issue_q <= 1'b0;
          end
        end
        StDrain: begin
          if ((vld_sr_q == '0) && !cmp_valid_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // In-flight tracking. Results return in issue order, so one running counter
  // recovers the nonce of each valid tail and no nonce is stored per stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_sr_q      <= '0;
      check_nonce_q <= '0;
      cmp_valid_q   <= 1'b0;
      cmp_golden_q  <= 1'b0;
      cmp_nonce_q   <= '0;
    end else if (bus.abort) begin
      vld_sr_q    <= '0;
      cmp_valid_q <= 1'b0;
    end else begin
      vld_sr_q    <= (vld_sr_q << 1) | LATENCY'(issue_q);
      cmp_valid_q <= tail;
      if (start_ok) begin
        check_nonce_q <= bus.nonce_start;
      end else if (tail) begin
        cmp_golden_q  <= (hash_v <= target_q);
        cmp_nonce_q   <= check_nonce_q;
        check_nonce_q <= check_nonce_q + 32'd1;
      end
    end
  end

  // Golden FIFO. Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && bus.golden_ready;
  assign push    = cmp_valid_q && cmp_golden_q && !bus.abort;
  // A simultaneous pop frees the head slot, which becomes the write slot.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (start_ok)  overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= cmp_nonce_q;
  end

  assign bus.nonce_out    = nonce_q;
  assign bus.issue_valid  = issue_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.overflow     = overflow_q;
  assign bus.golden_valid = !empty;
  assign bus.golden_nonce = empty ? 32'd0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: doc/golden_nonce_scanner.md
Name: golden_nonce_scanner

Overview:
Downstream and control companion of the chained sha256_transform double-hash pipeline. It issues one nonce per cycle into the fully pipelined hasher and tracks each nonce through the fixed pipeline latency. It compares every returned double-SHA256 result against a 256-bit target and queues winning ("golden") nonces in a small FIFO with a valid/ready handshake toward the host/UART side.

Parameters:
- LATENCY, 128, clock edges from the pipeline sampling nonce_out to the matching hash_in being valid; must be ≥1.
- FIFO_DEPTH, 4, golden-nonce FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; loads the range and begins a scan. Ignored while busy=1.
- abort  in  1  stops issuing and flushes in-flight tracking.
- nonce_start  in  32  first nonce; sampled on start.
- nonce_end  in  32  last nonce, inclusive; sampled on start.
- target  in  256  big-endian difficulty target; sampled on start.
- nonce_out  out  32  nonce presented to the hash pipeline.
- issue_valid  out  1  nonce_out is a real issue this cycle.
- hash_in  in  256  final hash from the pipeline, word-reversed layout: H0 in [31:0], H7 in [255:224].
- golden_valid  out  1  FIFO not empty.
- golden_ready  in  1  consumer accepts the head entry.
- golden_nonce  out  32  FIFO head nonce.
- busy  out  1  state ≠ IDLE.
- overflow  out  1  sticky; a golden nonce was dropped.

Behaviour:
- Reset values: nonce_out=0, issue_valid=0, golden_valid=0, golden_nonce=0, busy=0, overflow=0. FIFO is empty, valid shift register is cleared, state=IDLE.
- States:
  - IDLE → RUN on start: nonce_out←nonce_start, check_nonce←nonce_start, overflow←0, target latched.
  - RUN: issue_valid=1 every cycle. nonce_out increments modulo 2^32 each edge. After the edge that issues nonce_end, go to DRAIN.
  - DRAIN: issue_valid=0. Go to IDLE once the valid shift register is all zero and the compare stage is empty.
- Wrap-around: if nonce_end < nonce_start, the scan passes through 0xFFFFFFFF→0x00000000. If nonce_end == nonce_start, exactly one nonce is issued.
- In-flight tracking: a LATENCY-bit shift register receives issue_valid each edge. Its tail bit marks hash_in as valid on that edge.
  - Each valid tail compares hash_in for the nonce held in check_nonce, then check_nonce increments.
  - No nonce is ever stored per stage.
- Hash value: V = {bswap(H7), bswap(H6), …, bswap(H0)}, where bswap reverses the 4 bytes of each word. A nonce is golden iff V ≤ latched target (unsigned).
- Compare result and nonce are registered once; the FIFO write happens on the following edge. For a nonce sampled at edge E, golden_valid rises after edge E+LATENCY+1 (FIFO previously empty).
- FIFO behaviour:
  - Pop occurs on any edge with golden_valid && golden_ready.
  - Push while full with a simultaneous pop: both occur and nothing is dropped.
  - Push while full without a pop: the new nonce is dropped and overflow←1.
  - overflow stays set until the next accepted start.
  - golden_nonce = head entry; 0 when empty.
- abort (any state): state→IDLE, issue_valid→0 on the next edge, shift register and compare stage cleared. FIFO contents and overflow are retained. abort and start on the same edge: abort wins.
- start while busy is ignored, and no latched value changes.

Test Plan:
- Bench pipeline model (delay LATENCY) returns all-zero hash for nonce 0x00000010 and all-ones otherwise. target=1, range 0x0..0x1F → exactly one golden_nonce=0x00000010, golden_valid rising LATENCY+1 edges after 0x10 is issued. busy drops after DRAIN. overflow=0.
- Same model, range 0xFFFFFFFE..0x00000001 → nonce_out sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001, then issue_valid=0. 4 issues total, no golden nonces.
- target all-ones, range 0..9, golden_ready=0 → FIFO holds 0,1,2,3 and overflow=1. Then hold golden_ready=1 → pops 0,1,2,3 in order, golden_valid=0 afterward.
- FIFO full with golden_ready=1 during continuous pushes (target all-ones, range 0..7) → all 8 nonces delivered in order, overflow=0.
- abort three cycles into a 0..99 run → issue_valid=0 next edge, busy=0, no further FIFO writes. A fresh start then scans a new range correctly.
- reset_n asserted mid-RUN, asynchronously between edges → all outputs go to their reset values immediately. A start pulse while busy is ignored, with nonce_out unchanged.
